regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-read-port register file for the RV32I pipeline core and its wider variants. It has one write port, NUM_RD registered read ports with write-first bypass, and an optional hardwired-zero entry 0. After reset, and on request, a built-in sequential clear engine zeroes every entry, so the array maps to block RAM without relying on `initial` values.

## Interface
- DATA_W, 32: entry width in bits.
- ADDR_W, 5: address width; DEPTH = 2**ADDR_W entries.
- NUM_RD, 2: number of read ports, range 1..4.
- ZERO_REG, 1: 1 = entry 0 reads as 0 and ignores writes; 0 = entry 0 is an ordinary register.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- write  in  1  write enable.
- wrAddr  in  ADDR_W  write address.
- wrData  in  DATA_W  write data.
- rdAddr  in  NUM_RD*ADDR_W  read addresses; port p occupies bits [p*ADDR_W +: ADDR_W].
- rdData  out  NUM_RD*DATA_W  read data; port p occupies bits [p*DATA_W +: DATA_W].
- clear  in  1  single-cycle request to re-zero the array.
- ready  out  1  1 = array initialised and accepting writes.

## Operation
- Two states: CLEAR and RUN.
- Reset (rst_n low), applied immediately:
  - state = CLEAR; clear counter cnt = 0.
  - ready = 0; all rdData = 0; all bypass/pipeline registers = 0.
- CLEAR, each rising edge:
  - write 0 to entry cnt, then cnt = cnt + 1.
  - On the edge that clears entry DEPTH-1: cnt wraps to 0, state goes to RUN, ready goes to 1.
  - write is ignored and dropped.
  - clear is ignored; the clear sequence is never restarted.
  - Read ports are still sampled, but rdData is forced to 0.
- RUN, write:
  - If write = 1 and not (ZERO_REG = 1 and wrAddr = 0): entry wrAddr = wrData at the edge.
- RUN, read, per port p:
  - rdAddr[p] is sampled at edge N.
  - rdData[p] holds entry contents as of just before edge N, valid from edge N until edge N+1.
- Bypass, write-first:
  - Condition: write = 1 and wrAddr = rdAddr[p] at the same edge, and the write is not dropped.
  - Result: rdData[p] returns wrData instead of the old contents.
  - Must hold for all ports at once, including several ports on the same address.
- Zero register: ZERO_REG = 1 and a sampled address of 0 returns 0 regardless of write/bypass.
- clear in RUN:
  - Sampled 1 at an edge: state = CLEAR, cnt = 0, ready = 0 from that edge.
  - A write presented on that same edge is dropped.
  - rdData for addresses sampled on that edge is still valid (normal RUN read).
- Reset mid-CLEAR or mid-RUN: aborts immediately; the clear sequence restarts from entry 0 after release.
- Array contents are not reset asynchronously; only the clear engine zeroes them.

## Timing
- Reset values: ready = 0, rdData = 0 on every port, state = CLEAR, cnt = 0.
- Clear latency, after rst_n rises:
  - Edge k (k = 1..DEPTH) zeroes entry k-1.
  - ready is 1 after edge DEPTH (32 edges at defaults).
  - The first write accepted is the one presented at edge DEPTH+1.
- Clear latency after a clear request sampled at edge N: ready = 0 after N; ready = 1 after edge N+DEPTH.
- Read latency: exactly 1 cycle, address registered. No combinational path from rdAddr to rdData.
- Write-to-read:
  - Same edge: bypass gives the new data.
  - Read sampled one or more edges after the write: data comes from the array.
  - There is no case with stale data.
- Throughput: one write and NUM_RD reads every cycle in RUN.

## Test plan
- Reset then init, defaults:
  - Stimulus: hold rst_n low 3 cycles, release, drive write=1 wrAddr=5 wrData=0xDEADBEEF on every edge.
  - Response: ready rises after edge 32; no write lands before then.
  - Then read every address: all entries read 0 except entry 5 = 0xDEADBEEF once the first RUN write lands.
- Write-first bypass:
  - Stimulus, in RUN: write=1 wrAddr=7 wrData=0x12345678, with rdAddr[0]=7 and rdAddr[1]=7 on the same edge.
  - Response: both rdData = 0x12345678 next cycle.
  - Following edge, reading 7 with no write: still 0x12345678.
- Zero register:
  - Stimulus: write wrAddr=0 wrData=0xFFFFFFFF, with rdAddr[0]=0 on the same edge.
  - Response: rdData[0]=0 on that read and on later reads.
  - Repeat with ZERO_REG=0: read returns 0xFFFFFFFF.
- Runtime clear:
  - Stimulus: fill entries 1..31 with their index; pulse clear together with a write to entry 3 = 0xAA.
  - Response: ready falls; it rises exactly 32 edges later; all entries read 0, including entry 3.
- Reset mid-clear:
  - Stimulus: assert rst_n low at edge 10 of a clear sequence.
  - Response: rdData and ready drop to 0 asynchronously; after release, ready rises 32 edges later.
- Parameter sweep:
  - Stimulus: DATA_W=64, ADDR_W=4, NUM_RD=3; random write/read traffic checked against a reference model.
  - Response: zero mismatches; ready rises after 16 edges.

Source files
------------

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
//
// Parametrised register file: one write port, NUM_RD registered read ports
// with write-first bypass, and an optional hardwired-zero entry 0. A built-in
// sequential clear engine zeroes every entry after reset and on request, so
// the storage array carries no reset and can map onto block RAM.
//
// Parameters
//   DATA_W    entry width in bits
//   ADDR_W    address width, DEPTH = 2**ADDR_W entries
//   NUM_RD    number of read ports (1..4)
//   ZERO_REG  1: entry 0 reads as zero and ignores writes
//
// Ports
//   clk       clock, rising edge
//   rst_n     asynchronous active-low reset
//   write     write enable
//   wrAddr    write address
//   wrData    write data
//   rdAddr    read addresses, port p at [p*ADDR_W +: ADDR_W]
//   rdData    registered read data, port p at [p*DATA_W +: DATA_W]
//   clear     single-cycle request to re-zero the array (honoured in RUN)
//   ready     1 when the array is initialised and accepting writes
// -----------------------------------------------------------------------------
module regfile_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_RD   = 2,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     write,
    input  logic [ADDR_W-1:0]        wrAddr,
    input  logic [DATA_W-1:0]        wrData,
    input  logic [NUM_RD*ADDR_W-1:0] rdAddr,
    output logic [NUM_RD*DATA_W-1:0] rdData,
    input  logic                     clear,
    output logic                     ready
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [0:0] {
        StClear = 1'b0,
        StRun   = 1'b1
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              ready_q;

    logic              run;
    logic              wr_accept;

    // Storage array: deliberately no reset, the clear engine initialises it.
    logic [DATA_W-1:0] mem [DEPTH];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    assign run = (state_q == StRun);

    // A RUN write lands unless a clear request on the same edge drops it, or
    // it targets the hardwired-zero entry. Bypass uses the same qualifier so a
    // dropped write is never forwarded.
    assign wr_accept = run && write && !clear && !(ZERO_REG && (wrAddr == '0));

    // -------------------------------------------------------------------------
    // Single physical write port shared by the clear engine and the user port
    // -------------------------------------------------------------------------
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wrAddr;
        mem_wdata = wrData;
        if (!run) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = '0;
        end else if (wr_accept) begin
            mem_we    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // -------------------------------------------------------------------------
    // Control FSM: CLEAR walks cnt over every entry, RUN serves traffic
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StClear;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                StClear: begin
                    cnt_q <= cnt_q + ADDR_W'(1);
                    // Last entry zeroed on this edge; cnt wraps back to 0.
                    if (&cnt_q) begin
                        state_q <= StRun;
                        ready_q <= 1'b1;
                    end
                end
                StRun: begin
                    if (clear) begin
                        state_q <= StClear;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StClear;
                    cnt_q   <= '0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign ready = ready_q;

    // -------------------------------------------------------------------------
    // Read ports: address sampled at the edge, data registered
    // -------------------------------------------------------------------------
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd_d;
        logic [DATA_W-1:0] rd_q;

        assign ra = rdAddr[p*ADDR_W +: ADDR_W];

        // Priority: forced zero while clearing, then the zero entry, then
        // write-first bypass, then the stored contents.
        always_comb begin
            rd_d = mem[ra];
            if (!run) begin
                rd_d = '0;
            end else if (ZERO_REG && (ra == '0)) begin
                rd_d = '0;
            end else if (wr_accept && (wrAddr == ra)) begin
                rd_d = wrData;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_q <= '0;
            end else begin
                rd_q <= rd_d;
            end
        end

        assign rdData[p*DATA_W +: DATA_W] = rd_q;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
//
// Drives two register files side by side from one clock and reset:
//   dut0: defaults (32-bit, 32 entries, 2 read ports, zero register on)
//   dut1: 64-bit, 16 entries, 3 read ports, zero register off
// A behavioural model tracks array contents, readiness and expected read data
// for both; a compare process checks every falling edge, and the directed
// sequence adds hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;

    logic         w0, clr0, rdy0;
    logic [4:0]   wa0;
    logic [31:0]  wd0;
    logic [9:0]   ra0;
    logic [63:0]  rd0;

    logic         w1, clr1, rdy1;
    logic [3:0]   wa1;
    logic [63:0]  wd1;
    logic [11:0]  ra1;
    logic [191:0] rd1;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    regfile_mp dut0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .write  (w0),
        .wrAddr (wa0),
        .wrData (wd0),
        .rdAddr (ra0),
        .rdData (rd0),
        .clear  (clr0),
        .ready  (rdy0)
    );

    regfile_mp #(
        .DATA_W   (64),
        .ADDR_W   (4),
        .NUM_RD   (3),
        .ZERO_REG (1'b0)
    ) dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .write  (w1),
        .wrAddr (wa1),
        .wrData (wd1),
        .rdAddr (ra1),
        .rdData (rd1),
        .clear  (clr1),
        .ready  (rdy1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, req, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    logic [63:0] mm     [2][32];
    logic [63:0] exp_rd [2][4];
    bit          m_rdy  [2];
    int          m_left [2];
    bit          in_we  [2];
    bit          in_clr [2];
    int          in_wa  [2];
    logic [63:0] in_wd  [2];
    int          in_ra  [2][4];

    function automatic int depth_of(input int i);
        return (i == 0) ? 32 : 16;
    endfunction

    function automatic int nrd_of(input int i);
        return (i == 0) ? 2 : 3;
    endfunction

    function automatic bit zr_of(input int i);
        return (i == 0);
    endfunction

    // Clearing is modelled as "array is zero from the start of the sequence":
    // nothing can observe the array until the sequence completes.
    task automatic model_step(input int i);
        bit lands;
        int a;
        if (!m_rdy[i]) begin
            for (int p = 0; p < 4; p++) exp_rd[i][p] = '0;
            m_left[i]--;
            if (m_left[i] == 0) m_rdy[i] = 1'b1;
        end else begin
            lands = in_we[i] && !in_clr[i];
            for (int p = 0; p < nrd_of(i); p++) begin
                a = in_ra[i][p];
                if (zr_of(i) && a == 0)              exp_rd[i][p] = '0;
                else if (lands && a == in_wa[i])     exp_rd[i][p] = in_wd[i];
                else                                 exp_rd[i][p] = mm[i][a];
            end
            if (lands && !(zr_of(i) && in_wa[i] == 0)) mm[i][in_wa[i]] = in_wd[i];
            if (in_clr[i]) begin
                m_rdy[i]  = 1'b0;
                m_left[i] = depth_of(i);
                for (int e = 0; e < 32; e++) mm[i][e] = '0;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < 2; i++) begin
                    m_rdy[i]  = 1'b0;
                    m_left[i] = depth_of(i);
                    for (int p = 0; p < 4; p++) exp_rd[i][p] = '0;
                    for (int e = 0; e < 32; e++) mm[i][e] = '0;
                end
            end else begin
                in_we[0] = w0;  in_clr[0] = clr0;  in_wa[0] = int'(wa0);  in_wd[0] = {32'h0, wd0};
                in_we[1] = w1;  in_clr[1] = clr1;  in_wa[1] = int'(wa1);  in_wd[1] = wd1;
                for (int p = 0; p < 2; p++) in_ra[0][p] = int'(ra0[p*5 +: 5]);
                for (int p = 0; p < 3; p++) in_ra[1][p] = int'(ra1[p*4 +: 4]);
                model_step(0);
                model_step(1);
            end
        end
    end

    // -------------------------------------------------------------- compare
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("cmp_ready0", {63'h0, rdy0}, {63'h0, m_rdy[0]});
                chk("cmp_ready1", {63'h0, rdy1}, {63'h0, m_rdy[1]});
                for (int p = 0; p < 2; p++)
                    chk($sformatf("cmp_rd0_p%0d", p), {32'h0, rd0[p*32 +: 32]}, exp_rd[0][p]);
                for (int p = 0; p < 3; p++)
                    chk($sformatf("cmp_rd1_p%0d", p), rd1[p*64 +: 64], exp_rd[1][p]);
            end
        end
    end

    // ------------------------------------------------------------- watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
        $fatal(1, "watchdog expired");
    end

    // ---------------------------------------------------------------- tasks
    // Counts rising edges from the next one until each DUT reports ready.
    task automatic wait_ready(input string name);
        int k0 = 0;
        int k1 = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (rdy0 && k0 == 0) k0 = k;
            if (rdy1 && k1 == 0) k1 = k;
            if (k0 != 0 && k1 != 0) break;
        end
        chk({name, "_lat0"}, 64'(k0), 64'd32);
        chk({name, "_lat1"}, 64'(k1), 64'd16);
    endtask

    task automatic read_all();
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            ra0 = {5'(31 - a), 5'(a)};
            ra1 = {4'(a + 5), 4'(15 - a), 4'(a)};
        end
        @(negedge clk);
    endtask

    // --------------------------------------------------------------- driver
    initial begin
        w0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEAD_BEEF; ra0 = '0; clr0 = 1'b0;
        w1 = 1'b1; wa1 = 4'd5; wd1 = 64'hDEAD_BEEF_CAFE_F00D; ra1 = '0; clr1 = 1'b0;
        rst_n = 1'b0;

        // Reset and initial clear with a write held on every edge.
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("rst_ready0", {63'h0, rdy0}, 64'd0);
        chk("rst_rd0", rd0, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready("init");
        @(negedge clk);
        @(negedge clk);           // edge DEPTH+1 of dut0 has taken the write
        w0 = 1'b0;
        w1 = 1'b0;
        read_all();
        ra0 = {5'd4, 5'd5};
        ra1 = {4'd4, 4'd0, 4'd5};
        @(posedge clk);
        #1;
        chk("init_e5", {32'h0, rd0[31:0]}, 64'hDEAD_BEEF);
        chk("init_e4", {32'h0, rd0[63:32]}, 64'd0);
        chk("init1_e5", rd1[63:0], 64'hDEAD_BEEF_CAFE_F00D);

        // Write-first bypass, several ports on the same address.
        @(negedge clk);
        w0 = 1'b1; wa0 = 5'd7; wd0 = 32'h1234_5678; ra0 = {5'd7, 5'd7};
        w1 = 1'b1; wa1 = 4'd7; wd1 = 64'h0123_4567_89AB_CDEF; ra1 = {4'd7, 4'd7, 4'd7};
        @(posedge clk);
        #1;
        chk("byp0_p0", {32'h0, rd0[31:0]}, 64'h1234_5678);
        chk("byp0_p1", {32'h0, rd0[63:32]}, 64'h1234_5678);
        chk("byp1_p2", rd1[191:128], 64'h0123_4567_89AB_CDEF);
        @(negedge clk);
        w0 = 1'b0;
        w1 = 1'b0;
        @(posedge clk);
        #1;
        chk("byp0_hold", {32'h0, rd0[31:0]}, 64'h1234_5678);

        // Zero register (dut0) against ordinary entry 0 (dut1).
        @(negedge clk);
        w0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFF_FFFF; ra0 = {5'd7, 5'd0};
        w1 = 1'b1; wa1 = 4'd0; wd1 = '1;            ra1 = {4'd7, 4'd7, 4'd0};
        @(posedge clk);
        #1;
        chk("zr0_same", {32'h0, rd0[31:0]}, 64'd0);
        chk("nozr1_same", rd1[63:0], 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        w0 = 1'b0;
        w1 = 1'b0;
        @(posedge clk);
        #1;
        chk("zr0_later", {32'h0, rd0[31:0]}, 64'd0);
        chk("nozr1_later", rd1[63:0], 64'hFFFF_FFFF_FFFF_FFFF);
        chk("pre_rst_rd0_p1", {32'h0, rd0[63:32]}, 64'h1234_5678);

        // Reset mid-RUN: outputs drop without waiting for a clock edge.
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_ready0", {63'h0, rdy0}, 64'd0);
        chk("async_rd0", rd0, 64'd0);
        chk("async_rd1", {63'h0, |rd1}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-clear at edge 10, then a full restart.
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midclr_ready0", {63'h0, rdy0}, 64'd0);
        chk("midclr_rd0", rd0, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready("reclear");

        // Fill entries with their index.
        for (int a = 1; a < 32; a++) begin
            @(negedge clk);
            w0 = 1'b1; wa0 = 5'(a); wd0 = 32'(a); ra0 = 10'($urandom);
            w1 = (a < 16); wa1 = 4'(a); wd1 = 64'(a); ra1 = 12'($urandom);
        end

        // Runtime clear together with a write that must be dropped.
        @(negedge clk);
        clr0 = 1'b1; w0 = 1'b1; wa0 = 5'd3; wd0 = 32'hAA; ra0 = {5'd3, 5'd3};
        clr1 = 1'b1; w1 = 1'b1; wa1 = 4'd3; wd1 = 64'hAA; ra1 = {4'd3, 4'd3, 4'd3};
        @(posedge clk);
        #1;
        chk("clr_rd0", {32'h0, rd0[31:0]}, 64'd3);
        chk("clr_rd1", rd1[63:0], 64'd3);
        chk("clr_ready0", {63'h0, rdy0}, 64'd0);
        chk("clr_ready1", {63'h0, rdy1}, 64'd0);
        clr0 = 1'b0; w0 = 1'b0;
        clr1 = 1'b0; w1 = 1'b0;
        wait_ready("rtclr");
        read_all();
        ra0 = {5'd3, 5'd3};
        ra1 = {4'd3, 4'd3, 4'd3};
        @(posedge clk);
        #1;
        chk("after_clr_e3", {32'h0, rd0[31:0]}, 64'd0);
        chk("after_clr1_e3", rd1[63:0], 64'd0);

        // Random traffic, with rare clear requests.
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            w0 = 1'($urandom); wa0 = 5'($urandom); wd0 = $urandom; ra0 = 10'($urandom);
            clr0 = ($urandom_range(0, 99) == 0);
            w1 = 1'($urandom); wa1 = 4'($urandom); wd1 = {$urandom, $urandom};
            ra1 = 12'($urandom);
            clr1 = ($urandom_range(0, 99) == 0);
            // Bias reads towards the address being written to exercise bypass.
            if ($urandom_range(0, 3) == 0) ra0[4:0] = wa0;
            if ($urandom_range(0, 3) == 0) ra1[11:8] = wa1;
        end
        @(negedge clk);
        w0 = 1'b0; clr0 = 1'b0;
        w1 = 1'b0; clr1 = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            if (rdy0 && rdy1) break;
        end
        #1;
        chk("final_ready0", {63'h0, rdy0}, 64'd1);
        chk("final_ready1", {63'h0, rdy1}, 64'd1);
        read_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
